// File: rtl/uart8_pkg.sv
// Shared types, constants and divider helpers for the 8N1 UART.
package uart8_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam int DEF_CLOCK_RATE = 12000000;
  localparam int DEF_BAUD_RATE  = 9600;
  localparam int OVERSAMPLE     = 16;
  localparam int DATA_BITS      = 8;
  localparam int MID_SAMPLE     = 8;

  function automatic int rx_tick_div(input int clock_rate, input int baud_rate);
    return clock_rate / (baud_rate * OVERSAMPLE);
  endfunction

  function automatic int tx_tick_div(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart8_baud_gen.sv
// Free-running dividers producing 1-clk rx oversample and tx bit ticks.
// Ticks are registered; no backpressure, counters never stall.
module uart8_baud_gen #(
  parameter int RX_DIV = 78,
  parameter int TX_DIV = 1250
) (
  input  logic clk,
  input  logic reset,
  output logic rx_tick,
  output logic tx_tick
);

  localparam int RW = $clog2(RX_DIV + 1);
  localparam int TW = $clog2(TX_DIV + 1);

  logic [RW-1:0] rx_cnt;
  logic [TW-1:0] tx_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt  <= '0;
      rx_tick <= 1'b0;
      tx_cnt  <= '0;
      tx_tick <= 1'b0;
    end else begin
      if (rx_cnt == RW'(RX_DIV - 1)) begin
        rx_cnt  <= '0;
        rx_tick <= 1'b1;
      end else begin
        rx_cnt  <= rx_cnt + RW'(1);
        rx_tick <= 1'b0;
      end
      if (tx_cnt == TW'(TX_DIV - 1)) begin
        tx_cnt  <= '0;
        tx_tick <= 1'b1;
      end else begin
        tx_cnt  <= tx_cnt + TW'(1);
        tx_tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart8.sv
// Full-duplex 8N1 UART: 16x oversampled receiver, 1x baud transmitter, registered flags.
// Define UART8_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit.
module uart8 import uart8_pkg::*; #(
  parameter int CLOCK_RATE = DEF_CLOCK_RATE,
  parameter int BAUD_RATE  = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rx,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] out,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  localparam int RX_TICK_DIV = rx_tick_div(CLOCK_RATE, BAUD_RATE);
  localparam int TX_TICK_DIV = tx_tick_div(CLOCK_RATE, BAUD_RATE);

  logic rx_tick, tx_tick;

  uart8_baud_gen #(
    .RX_DIV(RX_TICK_DIV),
    .TX_DIV(TX_TICK_DIV)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .rx_tick(rx_tick),
    .tx_tick(tx_tick)
  );

  logic rx_meta, rxs;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  logic smp;

`ifdef UART8_RX_MAJORITY_EN
  // Decisions move one tick later so the window covers ticks 7, 8 and 9.
  localparam int DEC_TICK = MID_SAMPLE + 1;
  logic [1:0] rx_hist;

  always_ff @(posedge clk) begin
    if (reset) rx_hist <= 2'b11;
    else if (rx_tick) rx_hist <= {rx_hist[0], rxs};
  end

  assign smp = maj3(rx_hist[1], rx_hist[0], rxs);
`else
  localparam int DEC_TICK = MID_SAMPLE;
  assign smp = rxs;
`endif

  localparam int STOP_WAIT = OVERSAMPLE - DEC_TICK;

  rx_state_t  rx_state;
  logic [3:0] rx_cnt;
  logic [2:0] rx_idx;
  logic [7:0] rx_shift;
  logic       stop_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      stop_bad <= 1'b0;
      rxBusy   <= 1'b0;
      rxDone   <= 1'b0;
      rxErr    <= 1'b0;
      out      <= '0;
    end else if (!rxEn) begin
      rx_state <= RX_IDLE;
      rxBusy   <= 1'b0;
      rxDone   <= 1'b0;
      rxErr    <= 1'b0;
    end else if (rx_tick) begin
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
            rxDone   <= 1'b0;
            rxErr    <= 1'b0;
          end
        end
        RX_START: begin
          if (rx_cnt == 4'(DEC_TICK - 1)) begin
            rx_cnt <= '0;
            if (!smp) begin
              rx_state <= RX_DATA;
              rxBusy   <= 1'b1;
              rx_idx   <= '0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + 4'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 4'(OVERSAMPLE - 1)) begin
            rx_cnt           <= '0;
            rx_shift[rx_idx] <= smp;
            if (rx_idx == 3'(DATA_BITS - 1)) begin
              rx_state <= RX_STOP;
              stop_bad <= 1'b0;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 4'd1;
          end
        end
        RX_STOP: begin
          // First half of the stop bit must read high on every sample.
          if (rx_cnt >= 4'(STOP_WAIT) && !smp) stop_bad <= 1'b1;
          if (rx_cnt == 4'(STOP_WAIT + MID_SAMPLE - 1)) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rxBusy   <= 1'b0;
            if (stop_bad || !smp) begin
              rxErr <= 1'b1;
            end else begin
              rxDone <= 1'b1;
              out    <= rx_shift;
            end
          end else begin
            rx_cnt <= rx_cnt + 4'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  tx_state_t  tx_state;
  logic [7:0] tx_data;
  logic [2:0] tx_idx;
  logic       tx_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_data  <= '0;
      tx_idx   <= '0;
      tx_armed <= 1'b0;
      txBusy   <= 1'b0;
      txDone   <= 1'b0;
      tx       <= 1'b1;
    end else if (!txEn) begin
      if (tx_state != TX_IDLE) begin
        tx_state <= TX_IDLE;
        txBusy   <= 1'b0;
        txDone   <= 1'b0;
        tx       <= 1'b1;
      end
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (txStart) begin
            tx_data  <= in;
            tx_armed <= 1'b0;
            txBusy   <= 1'b1;
            txDone   <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          // First tick after acceptance opens the start bit, the second closes it.
          if (tx_tick) begin
            if (!tx_armed) begin
              tx       <= 1'b0;
              tx_armed <= 1'b1;
            end else begin
              tx       <= tx_data[0];
              tx_idx   <= '0;
              tx_state <= TX_DATA;
            end
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_idx == 3'(DATA_BITS - 1)) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx     <= tx_data[tx_idx + 3'd1];
              tx_idx <= tx_idx + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            txBusy   <= 1'b0;
            txDone   <= 1'b1;
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart8.sv
// Scoreboarded bench for uart8: random and directed frames, tx decoded from the line.
module tb_uart8;

  localparam int CLK_RATE = 2457600;
  localparam int BAUD     = 9600;
  localparam int RXD      = CLK_RATE / (BAUD * 16);
  localparam int BIT      = CLK_RATE / BAUD;

  logic       clk = 1'b0;
  logic       reset, rxEn, rx, rxBusy, rxDone, rxErr;
  logic       txEn, txStart, txBusy, txDone, tx;
  logic [7:0] out, in;
  logic       rx_drv, loop;

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart8 #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rx(rx), .rxBusy(rxBusy),
    .rxDone(rxDone), .rxErr(rxErr), .out(out), .txEn(txEn), .txStart(txStart),
    .in(in), .txBusy(txBusy), .txDone(txDone), .tx(tx)
  );

  typedef struct packed {logic err; logic [7:0] data;} rx_exp_t;

  int         checks = 0;
  int         failures = 0;
  rx_exp_t    rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] last_good;
  logic       tx_mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rxBusy"}, rxBusy, 0);
    check({tag, "_rxDone"}, rxDone, 0);
    check({tag, "_rxErr"}, rxErr, 0);
    check({tag, "_out"}, out, 0);
    check({tag, "_txBusy"}, txBusy, 0);
    check({tag, "_txDone"}, txDone, 0);
    check({tag, "_tx"}, tx, 1);
  endtask

  // Expected outcome of a frame: good frames update the byte, bad ones keep the old one.
  task automatic expect_rx(input logic [7:0] b, input logic bad);
    rx_exp_t e;
    e.err  = bad;
    e.data = bad ? last_good : b;
    if (!bad) last_good = b;
    rx_q.push_back(e);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic bad);
    expect_rx(b, bad);
    rx_drv = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      clks(BIT);
    end
    rx_drv = 1'b1;
    if (bad) begin
      clks(2 * RXD);
      rx_drv = 1'b0;
      clks(2 * RXD);
      rx_drv = 1'b1;
      clks(BIT - 4 * RXD);
    end else begin
      clks(BIT);
    end
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (txBusy !== 1'b0 && n < 20 * BIT) begin
      clks(1);
      n++;
    end
    if (txBusy !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL tx_idle_timeout: txBusy=%0b after %0d clocks, required 0", txBusy, n);
    end
  endtask

  task automatic tx_send(input logic [7:0] b);
    wait_tx_idle();
    in      = b;
    txStart = 1'b1;
    tx_q.push_back(b);
    if (loop) expect_rx(b, 1'b0);
    clks(1);
    txStart = 1'b0;
    check("tx_accept_busy", txBusy, 1);
    check("tx_accept_done_clr", txDone, 0);
    // A second request while busy must not disturb the frame in flight.
    in      = ~b;
    txStart = 1'b1;
    clks(1);
    txStart = 1'b0;
  endtask

  initial begin : rx_mon
    logic pd, pe;
    rx_exp_t e;
    pd = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if ((rxDone === 1'b1 && !pd) || (rxErr === 1'b1 && !pe)) begin
        if (rx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: rxDone=%0b rxErr=%0b out=%0h, required no event", rxDone, rxErr, out);
        end else begin
          e = rx_q.pop_front();
          check("rx_err", rxErr, e.err);
          check("rx_done", rxDone, !e.err);
          check("rx_out", out, e.data);
          check("rx_busy_after", rxBusy, 0);
        end
      end
      pd = (rxDone === 1'b1);
      pe = (rxErr === 1'b1);
    end
  end

  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && prev && tx === 1'b0) begin
        if (tx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected: start bit seen, required idle line");
        end else begin
          b = tx_q.pop_front();
          repeat (BIT / 2) @(negedge clk);
          check("tx_start_bit", tx, 0);
          for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            check($sformatf("tx_bit%0d", i), tx, (b >> i) & 8'h01);
            check("tx_busy_mid", txBusy, 1);
          end
          repeat (BIT) @(negedge clk);
          check("tx_stop_bit", tx, 1);
          repeat (BIT / 2 - 1) @(negedge clk);
          check("tx_done_early", txDone, 0);
          @(negedge clk);
          check("tx_done_end", txDone, 1);
          check("tx_busy_end", txBusy, 0);
        end
      end
      prev = tx;
    end
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation exceeded 150000 clocks, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       bad, busy_seen;
    int         n;
    reset = 1'b1; rxEn = 1'b0; rx_drv = 1'b1; loop = 1'b0;
    txEn = 1'b0; txStart = 1'b0; in = 8'h00; tx_mon_en = 1'b1; last_good = 8'h00;
    clks(3);
    check_reset("init");
    reset = 1'b0; rxEn = 1'b1; txEn = 1'b1;
    clks(2 * BIT);

    send_rx(8'h55, 1'b0);
    clks(BIT);
    send_rx(8'h55, 1'b1);
    clks(BIT);

    busy_seen = 1'b0;
    rx_drv = 1'b0;
    clks(3 * RXD);
    rx_drv = 1'b1;
    for (int i = 0; i < 20 * RXD; i++) begin
      clks(1);
      if (rxBusy) busy_seen = 1'b1;
    end
    check("glitch_busy_seen", busy_seen, 0);
    check("glitch_rxDone", rxDone, 0);
    check("glitch_rxErr", rxErr, 0);
    check("glitch_out", out, last_good);

    tx_send(8'hA3);
    wait_tx_idle();
    clks(BIT);

    loop = 1'b1;
    tx_send(8'h00);
    tx_send(8'hFF);
    wait_tx_idle();
    clks(BIT);
    loop = 1'b0;

    for (int k = 0; k < 8; k++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      send_rx(b, bad);
      clks($urandom_range(0, BIT));
    end

    loop = 1'b1;
    for (int k = 0; k < 3; k++) tx_send(8'($urandom_range(0, 255)));
    wait_tx_idle();
    clks(BIT);
    loop = 1'b0;

    // Receiver enable dropped partway through a data bit.
    rx_drv = 1'b0;
    clks(BIT);
    rx_drv = 1'b1;
    clks(BIT / 2);
    check("rxen_busy_before", rxBusy, 1);
    rxEn = 1'b0;
    clks(1);
    check("rxen_busy", rxBusy, 0);
    check("rxen_done", rxDone, 0);
    check("rxen_err", rxErr, 0);
    check("rxen_out_kept", out, last_good);
    rxEn = 1'b1;
    clks(10 * BIT);

    // Reset landing while both directions are mid-frame.
    tx_mon_en = 1'b0;
    in = 8'($urandom_range(0, 255));
    txStart = 1'b1;
    clks(1);
    txStart = 1'b0;
    rx_drv = 1'b0;
    clks(BIT);
    rx_drv = 1'b1;
    clks(BIT);
    check("mid_rxBusy", rxBusy, 1);
    check("mid_txBusy", txBusy, 1);
    reset = 1'b1;
    clks(1);
    check_reset("midrst");
    reset = 1'b0;
    last_good = 8'h00;
    clks(12 * BIT);
    tx_mon_en = 1'b1;

    n = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0) && n < 30 * BIT) begin
      clks(1);
      n++;
    end
    check("rx_q_drained", rx_q.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
